usrt_rx_ctrl: RTL and testbench
===============================

# usrt_rx_ctrl

Receive-side sequencer for the USRT. It samples the serial line on bit-enable strobes, assembles a start/data/parity/stop frame, and presents the 11-bit frame to the parity checker. It then collects the checker's registered result two clocks later and pushes data plus error flags into a small output FIFO with a valid/ready handshake toward the host logic.

## Interface
Parameters:
- FIFO_DEPTH, 2: output FIFO entries; power of two, ≥2.

Ports:
- i_Pclk  in  1  clock; all logic on rising edge.
- i_Reset  in  1  reset, synchronous, active-high.
- i_BitEn  in  1  bit strobe; i_Rx is sampled only on cycles with i_BitEn=1.
- i_Rx  in  1  serial data, idle high, LSB first.
- i_Parity  in  2  01 even, 10 odd, 00/11 none; latched at start-bit detection.
- i_ClrErr  in  1  clears o_Overrun.
- o_ChkData  out  11  frame to parity checker: [0] start, [8:1] data, [9] parity (0 when none), [10] stop.
- o_ChkParity  out  2  latched parity mode to checker.
- i_ChkData  in  8  checker registered data.
- i_ChkOK  in  1  checker registered parity result.
- o_Data  out  8  FIFO head data.
- o_ParErr  out  1  FIFO head parity error (=~i_ChkOK at capture).
- o_FrmErr  out  1  FIFO head framing error (stop bit sampled 0).
- o_Valid  out  1  FIFO non-empty.
- i_Ready  in  1  consumer accepts head when o_Valid&&i_Ready.
- o_Overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- o_Busy  out  1  receive FSM not IDLE.

## Operation
- Receive FSM, two states:
  - IDLE: on i_BitEn&&!i_Rx, go to RECV. Clear the bit counter and latch i_Parity into o_ChkParity.
  - RECV: on each i_BitEn, shift i_Rx into the frame register, LSB first. Frame length after start is 10 bits with parity and 9 without. On the stop-bit strobe:
    - load o_ChkData with {stop, parity-or-0, data[7:0], 1'b0};
    - set eval stage s1;
    - return to IDLE.
  - i_BitEn=0 cycles change nothing.
- Evaluation pipeline, independent of the FSM:
  - s1 → s2 on the next edge; the checker registers its result on that same edge.
  - On the edge after s2, push {i_ChkData, ~i_ChkOK, ~o_ChkData[10]} into the FIFO.
  - o_ChkData holds until the next frame load.
- FIFO:
  - push and pop in the same cycle are always both accepted, including when full;
  - push when full with no pop drops the frame and sets o_Overrun;
  - pop when empty is ignored;
  - outputs show the head entry and are undefined-stable (hold last value) when o_Valid=0.
- o_Overrun: set by a drop, cleared by i_ClrErr; set wins on a simultaneous drop and clear.
- Start detection only occurs in IDLE. A 0 on the line in RECV is data.

## Timing
- Reset values: o_ChkData=11'h400, o_ChkParity=00, o_Data=0, o_ParErr=0, o_FrmErr=0, o_Valid=0, o_Overrun=0, o_Busy=0; FSM IDLE; s1=s2=0; FIFO empty.
- Stop bit captured at edge E0 → o_ChkData valid after E0 → checker output valid after E1 → FIFO push at E2 → o_Valid=1 after E2 when the FIFO was empty. Latency from stop strobe to o_Valid is 3 edges.
- Back-to-back frames: a start strobe is legal on the first i_BitEn after the stop strobe, including E1 or E2. Frames cannot overlap in evaluation because minimum frame spacing is 10 strobes.
- Reset mid-frame or mid-evaluation: partial frame and pending s1/s2 are discarded; no push.

## Test plan
- Even parity, send 0xA5 (bits 0,1,0,1,0,0,1,0,1,0,1 in line order, parity 0, stop 1) → one entry: o_Data=A5, o_ParErr=0, o_FrmErr=0; o_Valid rises 3 edges after the stop strobe.
- Odd parity, send 0x3C with parity bit 0 (wrong) → o_Data=3C, o_ParErr=1. Resend with parity 1 → o_ParErr=0.
- No parity, send 0x81 with stop 0 (9 bits after start) → o_Data=81, o_FrmErr=1, o_ParErr=0, o_ChkData[9]=0.
- FIFO_DEPTH=2, i_Ready=0, send 3 frames (0x11, 0x22, 0x33) → o_Overrun=1, FIFO holds 11 then 22. Pulse i_ClrErr → o_Overrun=0. A 4th frame pushed in the same cycle as a pop is accepted.
- Assert i_Reset after the 5th data bit of a frame → all outputs at reset values, no entry produced. The next full frame 0x5A is received correctly.
- Strobe i_BitEn every cycle, two back-to-back even-parity frames 0x00 and 0xFF → both entries in order, with no errors.

Source files
------------

// File: rtl/usrt_rx_ctrl.sv
// USRT receive sequencer: assembles start/data/parity/stop frames from strobed line samples,
// hands them to the parity checker and queues the checked result in a small output FIFO.
module usrt_rx_ctrl #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        i_Pclk,
    input  logic        i_Reset,
    input  logic        i_BitEn,
    input  logic        i_Rx,
    input  logic [1:0]  i_Parity,
    input  logic        i_ClrErr,
    output logic [10:0] o_ChkData,
    output logic [1:0]  o_ChkParity,
    input  logic [7:0]  i_ChkData,
    input  logic        i_ChkOK,
    output logic [7:0]  o_Data,
    output logic        o_ParErr,
    output logic        o_FrmErr,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic        o_Overrun,
    output logic        o_Busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_e;

    state_e        state_q;
    logic [3:0]    bitCnt_q;
    logic [7:0]    data_q;
    logic          parBit_q;
    logic [10:0]   chkData_q;
    logic [1:0]    chkParity_q;
    logic          s1_q;
    logic          s2_q;

    logic          parEn;
    logic [3:0]    stopIdx;

    assign parEn   = chkParity_q[0] ^ chkParity_q[1];
    assign stopIdx = parEn ? 4'd9 : 4'd8;

    // Bit counter indexes the bits after start: 0..7 data, 8 parity or stop, 9 stop.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= 4'd0;
            data_q      <= 8'h00;
            parBit_q    <= 1'b0;
            chkData_q   <= 11'h400;
            chkParity_q <= 2'b00;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
        end else begin
            s1_q <= 1'b0;
            s2_q <= s1_q;
            if (i_BitEn) begin
                case (state_q)
                    IDLE: begin
                        if (!i_Rx) begin
                            state_q     <= RECV;
                            bitCnt_q    <= 4'd0;
                            chkParity_q <= i_Parity;
                        end
                    end
                    RECV: begin
                        bitCnt_q <= bitCnt_q + 4'd1;
                        if (bitCnt_q < 4'd8) begin
                            data_q[bitCnt_q[2:0]] <= i_Rx;
                        end
                        if (bitCnt_q == 4'd8) begin
                            parBit_q <= i_Rx;
                        end
                        if (bitCnt_q == stopIdx) begin
                            chkData_q <= {i_Rx, parEn & parBit_q, data_q, 1'b0};
                            s1_q      <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [9:0]    hold_q;
    logic [9:0]    head_d;
    logic          overrun_q;
    logic          full;
    logic          doPop;
    logic          doPush;
    logic          drop;

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign doPop  = (count_q != '0) && i_Ready;
    assign doPush = s2_q && (!full || doPop);
    assign drop   = s2_q && full && !doPop;

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CW'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_Pclk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= {i_ChkData, ~i_ChkOK, ~chkData_q[10]};
        end
    end

    // hold_q remembers the last head so outputs stay put once the FIFO drains.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            hold_q    <= 10'h000;
            overrun_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_d;
            if (count_q != '0) begin
                hold_q <= mem_q[rdPtr_q];
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (i_ClrErr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign head_d      = (count_q != '0) ? mem_q[rdPtr_q] : hold_q;
    assign o_Data      = head_d[9:2];
    assign o_ParErr    = head_d[1];
    assign o_FrmErr    = head_d[0];
    assign o_Valid     = (count_q != '0);
    assign o_Overrun   = overrun_q;
    assign o_Busy      = (state_q == RECV);
    assign o_ChkData   = chkData_q;
    assign o_ChkParity = chkParity_q;

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// Bench for usrt_rx_ctrl: emulates the parity checker, models the output FIFO as a queue
// and compares the FIFO head, valid and overrun flags every cycle.
module tb_usrt_rx_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bitEn = 1'b0;
    logic        rx = 1'b1;
    logic [1:0]  parity = 2'b00;
    logic        clrErr = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  chkDataR = 8'h00;
    logic        chkOkR = 1'b0;
    logic [10:0] oChkData;
    logic [1:0]  oChkParity;
    logic [7:0]  oData;
    logic        oParErr;
    logic        oFrmErr;
    logic        oValid;
    logic        oOverrun;
    logic        oBusy;

    int          nCompared = 0;
    int          nFailed = 0;
    int          readyMode = 0;

    logic [9:0]  modelQ[$];
    logic [9:0]  lastHead = 10'h000;
    logic [9:0]  expHead;
    logic [9:0]  pendEntry = 10'h000;
    logic [9:0]  curEntry = 10'h000;
    bit          modelOvr = 1'b0;
    bit          stopStrobe = 1'b0;
    bit          popNow;
    bit          dropNow;
    int          pendCnt = -1;

    usrt_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .i_Pclk     (clk),
        .i_Reset    (reset),
        .i_BitEn    (bitEn),
        .i_Rx       (rx),
        .i_Parity   (parity),
        .i_ClrErr   (clrErr),
        .o_ChkData  (oChkData),
        .o_ChkParity(oChkParity),
        .i_ChkData  (chkDataR),
        .i_ChkOK    (chkOkR),
        .o_Data     (oData),
        .o_ParErr   (oParErr),
        .o_FrmErr   (oFrmErr),
        .o_Valid    (oValid),
        .i_Ready    (ready),
        .o_Overrun  (oOverrun),
        .o_Busy     (oBusy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Registered parity checker sitting beside the DUT.
    always @(posedge clk) begin
        chkDataR <= oChkData[8:1];
        case (oChkParity)
            2'b01:   chkOkR <= ~(^oChkData[9:1]);
            2'b10:   chkOkR <= ^oChkData[9:1];
            default: chkOkR <= 1'b1;
        endcase
    end

    always @(posedge clk) begin
        #2;
        case (readyMode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Compare against the queue model, then advance the model for the coming edge.
    always @(negedge clk) begin
        expHead = (modelQ.size() > 0) ? modelQ[0] : lastHead;
        checkOutput("valid", {31'd0, oValid}, {31'd0, modelQ.size() > 0});
        checkOutput("data", {24'd0, oData}, {24'd0, expHead[9:2]});
        checkOutput("parErr", {31'd0, oParErr}, {31'd0, expHead[1]});
        checkOutput("frmErr", {31'd0, oFrmErr}, {31'd0, expHead[0]});
        checkOutput("overrun", {31'd0, oOverrun}, {31'd0, modelOvr});
        if (reset) begin
            modelQ.delete();
            lastHead = 10'h000;
            modelOvr = 1'b0;
            pendCnt  = -1;
        end else begin
            popNow  = (modelQ.size() > 0) && ready;
            dropNow = 1'b0;
            if (popNow) begin
                lastHead = modelQ.pop_front();
            end
            if (pendCnt == 0) begin
                if (modelQ.size() < DEPTH) begin
                    modelQ.push_back(pendEntry);
                end else begin
                    dropNow = 1'b1;
                end
                pendCnt = -1;
            end else if (pendCnt > 0) begin
                pendCnt--;
            end
            if (dropNow) begin
                modelOvr = 1'b1;
            end else if (clrErr) begin
                modelOvr = 1'b0;
            end
            if (bitEn && stopStrobe) begin
                pendEntry = curEntry;
                pendCnt   = 1;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] pm, input bit pb,
                                 input bit stop, input int div);
        bit   hasPar;
        bit   perr;
        logic [10:0] bits;
        int   n;
        hasPar = (pm == 2'b01) || (pm == 2'b10);
        if (!hasPar) begin
            perr = 1'b0;
        end else if (pm == 2'b01) begin
            perr = (^d) ^ pb;
        end else begin
            perr = ~((^d) ^ pb);
        end
        curEntry = {d, perr, ~stop};
        n = hasPar ? 11 : 10;
        bits = hasPar ? {stop, pb, d, 1'b0} : {1'b0, stop, d, 1'b0};
        parity = pm;
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            bitEn = 1'b1;
            stopStrobe = (i == n - 1);
            @(posedge clk);
            #1;
            bitEn = 1'b0;
            stopStrobe = 1'b0;
            for (int k = 1; k < div; k++) begin
                @(posedge clk);
                #1;
            end
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] partial;
        idle(3);
        checkOutput("rstChkData", {21'd0, oChkData}, 32'h400);
        checkOutput("rstChkParity", {30'd0, oChkParity}, 32'h0);
        checkOutput("rstBusy", {31'd0, oBusy}, 32'h0);
        reset = 1'b0;
        readyMode = 1;
        idle(2);

        applyStimulus(8'hA5, 2'b01, 1'b0, 1'b1, 2);
        idle(6);
        applyStimulus(8'h3C, 2'b10, 1'b0, 1'b1, 1);
        idle(6);
        applyStimulus(8'h3C, 2'b10, 1'b1, 1'b1, 1);
        idle(6);

        applyStimulus(8'h81, 2'b00, 1'b0, 1'b0, 1);
        checkOutput("noParBit9", {31'd0, oChkData[9]}, 32'h0);
        checkOutput("noParStop", {31'd0, oChkData[10]}, 32'h0);
        checkOutput("noParData", {24'd0, oChkData[8:1]}, 32'h81);
        idle(6);

        readyMode = 0;
        idle(2);
        applyStimulus(8'h11, 2'b01, 1'b0, 1'b1, 1);
        applyStimulus(8'h22, 2'b01, 1'b0, 1'b1, 1);
        applyStimulus(8'h33, 2'b01, 1'b0, 1'b1, 1);
        idle(5);
        checkOutput("ovrSet", {31'd0, oOverrun}, 32'h1);
        checkOutput("ovrHead", {24'd0, oData}, 32'h11);
        clrErr = 1'b1;
        idle(1);
        clrErr = 1'b0;
        checkOutput("ovrClr", {31'd0, oOverrun}, 32'h0);
        applyStimulus(8'h44, 2'b01, 1'b0, 1'b1, 1);
        idle(1);
        readyMode = 1;
        idle(1);
        readyMode = 0;
        idle(1);
        checkOutput("pushPopHead", {24'd0, oData}, 32'h22);
        checkOutput("pushPopOvr", {31'd0, oOverrun}, 32'h0);
        checkOutput("pushPopValid", {31'd0, oValid}, 32'h1);
        readyMode = 1;
        idle(6);

        parity = 2'b01;
        partial = 8'h6B;
        rx = 1'b0;
        bitEn = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            rx = partial[i];
            idle(1);
        end
        bitEn = 1'b0;
        rx = 1'b1;
        checkOutput("midBusy", {31'd0, oBusy}, 32'h1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checkOutput("rstMidBusy", {31'd0, oBusy}, 32'h0);
        checkOutput("rstMidParity", {30'd0, oChkParity}, 32'h0);
        checkOutput("rstMidChkData", {21'd0, oChkData}, 32'h400);
        idle(6);
        checkOutput("rstMidValid", {31'd0, oValid}, 32'h0);
        applyStimulus(8'h5A, 2'b01, 1'b0, 1'b1, 1);
        idle(6);

        applyStimulus(8'h00, 2'b01, 1'b0, 1'b1, 1);
        applyStimulus(8'hFF, 2'b01, 1'b0, 1'b1, 1);
        idle(8);

        readyMode = 2;
        for (int f = 0; f < 30; f++) begin
            rd = 8'($urandom);
            applyStimulus(rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7) != 0, $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                clrErr = 1'b1;
                idle(1);
                clrErr = 1'b0;
            end
            idle($urandom_range(0, 2));
        end
        readyMode = 1;
        idle(20);
        checkOutput("drained", {31'd0, oValid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
